// File: rtl/clock_display_mux.sv
// Six-digit multiplexed 7-segment driver for an hr/min/sec time value, with a tear-free once-per-frame snapshot.
// Optional 12-hour display mode is enabled by defining DISP_12H_EN.
module clock_display_mux #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pm
);

  localparam int unsigned     CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_DASH  = 7'b0111111;
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] q;
    q = v / 6'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return r[3:0];
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [16:0]   in_q, in_d;
  logic [16:0]   snap_q, snap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          pm_q, pm_d;

  logic          stable_s;
  logic          tc_s;
  logic [4:0]    snap_hr_s;
  logic [5:0]    snap_min_s;
  logic [5:0]    snap_sec_s;
  logic          hr_ok_s, min_ok_s, sec_ok_s;
  logic [5:0]    hr_disp_s;
  logic [3:0]    hr_tens_s;

  // Scan counter, digit index and frame-boundary snapshot capture.
  always_comb begin
    in_d     = {hr, min, sec};
    stable_s = (in_q == in_d);
    tc_s     = (cnt_q == CNT_MAX);
    if (tc_s) begin
      cnt_d = '0;
      idx_d = (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
    // A changing input at the wrap keeps the previous frame's value whole.
    if (tc_s && (idx_q >= 3'd5) && stable_s) begin
      snap_d = in_q;
    end else begin
      snap_d = snap_q;
    end
  end

  // Digit decode from the snapshot for the digit currently selected by idx.
  always_comb begin
    snap_hr_s  = snap_q[16:12];
    snap_min_s = snap_q[11:6];
    snap_sec_s = snap_q[5:0];
    hr_ok_s    = (snap_hr_s <= 5'd23);
    min_ok_s   = (snap_min_s <= 6'd59);
    sec_ok_s   = (snap_sec_s <= 6'd59);
`ifdef DISP_12H_EN
    if (snap_hr_s == 5'd0) begin
      hr_disp_s = 6'd12;
    end else if (snap_hr_s > 5'd12) begin
      hr_disp_s = {1'b0, snap_hr_s - 5'd12};
    end else begin
      hr_disp_s = {1'b0, snap_hr_s};
    end
    pm_d = hr_ok_s && (snap_hr_s >= 5'd12);
`else
    hr_disp_s = {1'b0, snap_hr_s};
    pm_d      = 1'b0;
`endif
    hr_tens_s = bcd_tens(hr_disp_s);

    an_d  = 6'b111111;
    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0: begin
        an_d  = 6'b111110;
        seg_d = sec_ok_s ? seg_code(bcd_ones(snap_sec_s)) : SEG_DASH;
      end
      3'd1: begin
        an_d  = 6'b111101;
        seg_d = sec_ok_s ? seg_code(bcd_tens(snap_sec_s)) : SEG_DASH;
      end
      3'd2: begin
        an_d  = 6'b111011;
        seg_d = min_ok_s ? seg_code(bcd_ones(snap_min_s)) : SEG_DASH;
      end
      3'd3: begin
        an_d  = 6'b110111;
        seg_d = min_ok_s ? seg_code(bcd_tens(snap_min_s)) : SEG_DASH;
      end
      3'd4: begin
        an_d  = 6'b101111;
        seg_d = hr_ok_s ? seg_code(bcd_ones(hr_disp_s)) : SEG_DASH;
      end
      3'd5: begin
        an_d = 6'b011111;
        if (!hr_ok_s) begin
          seg_d = SEG_DASH;
`ifdef DISP_12H_EN
        end else if (hr_tens_s == 4'd0) begin
          seg_d = SEG_BLANK;
`endif
        end else begin
          seg_d = seg_code(hr_tens_s);
        end
      end
      default: begin
        an_d  = 6'b111111;
        seg_d = SEG_BLANK;
      end
    endcase

    // Colon dots sit after the minutes-ones and hours-ones digits.
    if (((idx_q == 3'd2) || (idx_q == 3'd4)) && !snap_sec_s[0]) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      in_q   <= 17'd0;
      snap_q <= 17'd0;
      an_q   <= 6'b111111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
      pm_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      in_q   <= in_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      pm_q   <= pm_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign pm  = pm_q;

endmodule
